led_panel_scan: RTL and testbench
=================================

# led_panel_scan

Scan controller that drives a HUB75-style RGB LED matrix from the per-pixel on/off bits produced by the PWM comparators. It generates the PWM threshold level and framebuffer column/row addresses upstream, and it shifts the returned colour bits into the panel. It also produces the panel shift clock, latch, output-enable and row-address lines. It sits between the framebuffer/comparator datapath and the panel connector pins.

## Interface
- PWM_WIDTH, 12: width of the PWM threshold level (matches the comparator width).
- COLS, 32: panel columns shifted per row; ≥1.
- ROW_BITS, 4: row address width; the panel scans 2^ROW_BITS row pairs.
- DISPLAY_CYCLES, 8: clocks that OE is held active per subframe; ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  run enable; sampled only in IDLE and at end of DISPLAY.
- pwmlvl  out  PWM_WIDTH  threshold level fed to the comparators.
- col  out  $clog2(COLS)  framebuffer column address.
- row  out  ROW_BITS  framebuffer row address (row being shifted).
- r0_in, g0_in, b0_in, r1_in, g1_in, b1_in  in  1 each  comparator outputs, upper/lower half; valid one cycle after col/row/pwmlvl.
- r0, g0, b0, r1, g1, b1  out  1 each  panel data pins.
- sclk  out  1  panel shift clock.
- lat  out  1  panel latch strobe.
- oe_n  out  1  panel output enable, active-low.
- addr  out  ROW_BITS  panel row address.
- frame_start  out  1  one-cycle pulse at the start of the first SHIFT of row 0, level 0.

## Operation
- States: IDLE, SHIFT, LATCH, DISPLAY. All outputs are registered.
- IDLE: oe_n=1, sclk=0, lat=0. If en=1, go to SHIFT next cycle.
- SHIFT: lasts 2*(COLS+1) cycles as slots s=0..COLS; each slot has phase 0 then phase 1.
  - col = s during slot s for s<COLS; col holds COLS-1 in slot COLS.
  - At the end of phase 1 of slot s (s<COLS), the data pins load the *_in bits for column s.
  - sclk=1 only in phase 1 of slots 1..COLS, giving exactly COLS rising edges; the data pins are stable across each edge.
  - oe_n=1 throughout SHIFT.
- LATCH: 1 cycle. lat=1, oe_n=1, addr <= row.
- DISPLAY: DISPLAY_CYCLES cycles with oe_n=0. In the last cycle, advance the sequence:
  - pwmlvl increments. When pwmlvl = 2^PWM_WIDTH-2, it wraps to 0 and row increments, wrapping mod 2^ROW_BITS.
  - Next state is SHIFT if en=1, else IDLE.
- Consequences of the level sweep:
  - Each row is shown for 2^PWM_WIDTH-1 subframes.
  - A pixel value p is lit in exactly p of them (comparator rule: lit when pix > lvl).
  - A pixel with value 0 is never lit; a pixel at full scale is always lit.
- en deasserted mid-SHIFT, LATCH or DISPLAY: the current subframe completes, then the block enters IDLE. pwmlvl and row are retained, and resuming continues from the next subframe.
- Asynchronous reset, at any time, forces:
  - state=IDLE, pwmlvl=0, row=0, col=0, addr=0.
  - All data pins=0, sclk=0, lat=0, oe_n=1, frame_start=0.

## Timing
- Subframe period with en held high: 2*(COLS+1) + 1 + DISPLAY_CYCLES cycles; no IDLE cycles between subframes.
- Row period = (2^PWM_WIDTH-1) × subframe period. Frame period = 2^ROW_BITS × row period.
- First SHIFT cycle after reset: one cycle after the first cycle in which en=1 is sampled in IDLE.
- Input latency: *_in must reflect col/row/pwmlvl driven in the previous cycle. col is stable for 2 cycles per column, so one-cycle synchronous RAM plus combinational compare is supported.
- pwmlvl and row change only on the DISPLAY→SHIFT/IDLE edge, never during SHIFT.
- frame_start is high in the first SHIFT cycle when row=0 and pwmlvl=0, including the first subframe after reset.
- lat and sclk are never high in the same cycle. oe_n=0 only in DISPLAY.

## Test plan
- Bench configuration for all scenarios: PWM_WIDTH=2, COLS=4, ROW_BITS=1, DISPLAY_CYCLES=3, giving a 14-cycle subframe.
- Reset, en=0: all outputs hold reset values for 20 cycles; oe_n=1, sclk=0.
- en=1 with a model returning r0_in = (col==2): exactly 4 sclk rises per subframe; r0 is 1 only at the 3rd rise; lat is high 1 cycle after SHIFT; oe_n=0 for 3 cycles; period is 14 cycles.
- Sequence check: pwmlvl steps 0,1,2,0 and row steps 0,0,0,1; addr follows row at LATCH; frame_start pulses every 84 cycles.
- Comparator model with pixel value 3 on all columns: r0 is high at all sclk edges in all 3 subframes; pixel value 0 is never high; pixel value 1 is high only when pwmlvl=0.
- Drop en in the middle of SHIFT of subframe (row 0, lvl 1): the subframe finishes LATCH and DISPLAY, then IDLE; re-raising en resumes with pwmlvl=2, row=0.
- Assert reset during DISPLAY: oe_n goes to 1 and every output returns to its reset value immediately, without waiting for a clock edge; after release, the sequence restarts at row 0, lvl 0 with frame_start.

Source files
------------

// File: rtl/led_panel_scan.sv
// HUB75 scan controller: sweeps PWM level and row, shifts comparator bits into the panel,
// and generates sclk/lat/oe_n/addr. All panel-facing outputs are registered.
module led_panel_scan #(
  parameter int PWM_WIDTH      = 12,
  parameter int COLS           = 32,
  parameter int ROW_BITS       = 4,
  parameter int DISPLAY_CYCLES = 8,
  localparam int COL_W         = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [PWM_WIDTH-1:0] pwmlvl,
  output logic [COL_W-1:0]     col,
  output logic [ROW_BITS-1:0]  row,
  input  logic                 r0_in,
  input  logic                 g0_in,
  input  logic                 b0_in,
  input  logic                 r1_in,
  input  logic                 g1_in,
  input  logic                 b1_in,
  output logic                 r0,
  output logic                 g0,
  output logic                 b0,
  output logic                 r1,
  output logic                 g1,
  output logic                 b1,
  output logic                 sclk,
  output logic                 lat,
  output logic                 oe_n,
  output logic [ROW_BITS-1:0]  addr,
  output logic                 frame_start
);

  localparam int SLOT_W = $clog2(COLS + 1);
  localparam int DISP_W = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;

  localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(COLS);
  localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(COLS - 1);
  localparam logic [DISP_W-1:0]    DISP_LAST = DISP_W'(DISPLAY_CYCLES - 1);
  localparam logic [PWM_WIDTH-1:0] LVL_LAST  = PWM_WIDTH'((2 ** PWM_WIDTH) - 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_LATCH   = 2'd2;
  localparam logic [1:0] S_DISPLAY = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic                 phase_q, phase_d;
  logic [DISP_W-1:0]    disp_q, disp_d;
  logic [PWM_WIDTH-1:0] lvl_q, lvl_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [5:0]           data_q, data_d;
  logic                 sclk_q, sclk_d;
  logic                 lat_q, lat_d;
  logic                 oe_n_q, oe_n_d;
  logic [ROW_BITS-1:0]  addr_q, addr_d;
  logic                 fs_q, fs_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    phase_d = phase_q;
    disp_d  = disp_q;
    lvl_d   = lvl_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_SHIFT;
          slot_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_SHIFT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (slot_q == SLOT_LAST) state_d = S_LATCH;
          else                     slot_d  = slot_q + 1'b1;
        end
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
        disp_d  = '0;
      end
      S_DISPLAY: begin
        if (disp_q == DISP_LAST) begin
          // Level sweep stops one short of full scale so p lights exactly p subframes.
          if (lvl_q == LVL_LAST) begin
            lvl_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            lvl_d = lvl_q + 1'b1;
          end
          state_d = en ? S_SHIFT : S_IDLE;
          slot_d  = '0;
          phase_d = 1'b0;
        end else begin
          disp_d = disp_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so every pin is a flop.
  always_comb begin
    col_d = col_q;
    if (state_d == S_SHIFT) begin
      col_d = (slot_d < SLOT_LAST) ? COL_W'(slot_d) : COL_LAST;
    end
    data_d = data_q;
    if (state_q == S_SHIFT && phase_q && slot_q != SLOT_LAST) begin
      data_d = {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in};
    end
    sclk_d = (state_d == S_SHIFT) && phase_d && (slot_d != '0);
    lat_d  = (state_d == S_LATCH);
    oe_n_d = (state_d != S_DISPLAY);
    addr_d = (state_d == S_LATCH) ? row_q : addr_q;
    fs_d   = (state_d == S_SHIFT) && (state_q != S_SHIFT) && (lvl_d == '0) && (row_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      phase_q <= 1'b0;
      disp_q  <= '0;
      lvl_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      addr_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
      lvl_q   <= lvl_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      addr_q  <= addr_d;
      fs_q    <= fs_d;
    end
  end

  assign pwmlvl      = lvl_q;
  assign row         = row_q;
  assign col         = col_q;
  assign {r0, g0, b0, r1, g1, b1} = data_q;
  assign sclk        = sclk_q;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign addr        = addr_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_panel_scan.sv
// Directed bench for led_panel_scan with a one-cycle-latency comparator model on the inputs.
module tb_led_panel_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] pwmlvl;
  logic [1:0] col;
  logic       row;
  logic       addr;
  logic       r0_in, g0_in, b0_in, r1_in, g1_in, b1_in;
  logic       r0, g0, b0, r1, g1, b1;
  logic       sclk, lat, oe_n, frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_panel_scan #(
    .PWM_WIDTH      (2),
    .COLS           (4),
    .ROW_BITS       (1),
    .DISPLAY_CYCLES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .pwmlvl      (pwmlvl),
    .col         (col),
    .row         (row),
    .r0_in       (r0_in),
    .g0_in       (g0_in),
    .b0_in       (b0_in),
    .r1_in       (r1_in),
    .g1_in       (g1_in),
    .b1_in       (b1_in),
    .r0          (r0),
    .g0          (g0),
    .b0          (b0),
    .r1          (r1),
    .g1          (g1),
    .b1          (b1),
    .sclk        (sclk),
    .lat         (lat),
    .oe_n        (oe_n),
    .addr        (addr),
    .frame_start (frame_start)
  );

  logic [15:0] ov;
  logic [5:0]  pins;
  assign ov   = {pwmlvl, col, row, r0, g0, b0, r1, g1, b1, sclk, lat, oe_n, addr, frame_start};
  assign pins = {r0, g0, b0, r1, g1, b1};

  localparam logic [15:0] RST_VEC = 16'h0004;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Pixel map: r0 lit only in column 2, g0 value 3, b0 value 0, r1 value 1, g1 value 2, b1 only column 0.
  function automatic logic [5:0] comp(input logic [1:0] c, input logic [1:0] l);
    return {c == 2'd2, 2'd3 > l, 1'b0, 2'd1 > l, 2'd2 > l, c == 2'd0};
  endfunction

  logic [1:0] prev_col, prev_lvl;
  initial begin
    {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = '0;
    prev_col = '0;
    prev_lvl = '0;
    forever begin
      @(negedge clk);
      {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = comp(prev_col, prev_lvl);
      prev_col = col;
      prev_lvl = pwmlvl;
    end
  end

  // Starts at the negedge of the first SHIFT cycle, ends at the negedge 14 cycles later.
  task automatic run_subframe(input int lvl_e, input int row_e, input int drop_at);
    logic [13:0] sclk_map, lat_map, oe_map;
    logic [19:0] col_seq, col_exp;
    logic [23:0] pat, pat_exp;
    logic [5:0]  prev_pins;
    logic        fs0, row0, addr_lat;
    logic [1:0]  lvl0;
    int          nrise, unstable, fs_cnt, chg, s;
    logic        fs_exp;
    sclk_map = '0; lat_map = '0; oe_map = '0; col_seq = '0; pat = '0;
    nrise = 0; unstable = 0; fs_cnt = 0; chg = 0;
    fs0 = 1'b0; row0 = 1'b0; lvl0 = '0; addr_lat = 1'b0;
    prev_pins = pins;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        fs0 = frame_start; lvl0 = pwmlvl; row0 = row;
      end else if (pwmlvl !== lvl0 || row !== row0) begin
        chg++;
      end
      fs_cnt += int'(frame_start);
      sclk_map[i] = sclk;
      lat_map[i]  = lat;
      oe_map[i]   = ~oe_n;
      if (i < 10) col_seq[2*i +: 2] = col;
      if (i == 10) addr_lat = addr;
      if (sclk === 1'b1 && pins !== prev_pins) unstable++;
      if (sclk === 1'b1 && nrise < 4) begin
        pat[nrise*6 +: 6] = pins;
        nrise++;
      end
      prev_pins = pins;
      if (i == drop_at) en = 1'b0;
      @(negedge clk);
    end
    col_exp = '0;
    for (int i = 0; i < 10; i++) begin
      s = i / 2;
      col_exp[2*i +: 2] = (s < 4) ? 2'(s) : 2'd3;
    end
    for (int k = 0; k < 4; k++) begin
      pat_exp[k*6 +: 6] = {k == 2, 1'b1, 1'b0, lvl_e == 0, lvl_e < 2, k == 0};
    end
    fs_exp = (lvl_e == 0 && row_e == 0);
    check_val("frame_start_first", 32'(fs0), 32'(fs_exp));
    check_val("frame_start_count", fs_cnt, 32'(fs_exp));
    check_val("pwmlvl", 32'(lvl0), lvl_e);
    check_val("row", 32'(row0), row_e);
    check_val("lvl_row_stable", chg, 0);
    check_val("col_seq", 32'(col_seq), 32'(col_exp));
    check_val("sclk_map", 32'(sclk_map), 32'h02A8);
    check_val("lat_map", 32'(lat_map), 32'h0400);
    check_val("oe_map", 32'(oe_map), 32'h3800);
    check_val("addr_at_latch", 32'(addr_lat), row_e);
    check_val("data_at_rises", 32'(pat), 32'(pat_exp));
    check_val("data_stable", unstable, 0);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("idle_hold", 32'(ov), 32'(RST_VEC));
    end

    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      run_subframe(k % 3, (k / 3) % 2, -1);
    end

    run_subframe(1, 0, 4);
    for (int i = 0; i < 5; i++) begin
      check_val("idle_after_drop", {27'd0, pwmlvl, row, sclk, lat, oe_n}, {27'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
    end
    en = 1'b1;
    @(negedge clk);
    run_subframe(2, 0, -1);

    repeat (12) @(negedge clk);
    check_val("oe_in_display", 32'(oe_n), 0);
    #2 reset = 1'b1;
    #1 check_val("async_reset", 32'(ov), 32'(RST_VEC));
    @(negedge clk);
    check_val("reset_held", 32'(ov), 32'(RST_VEC));
    reset = 1'b0;
    @(negedge clk);
    run_subframe(0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
